// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory load/store unit.
//   - DATA_W           : data path width (fixed at 32)
//   - SZ_BYTE/HALF/WORD: access size encodings on the size port (2'b11 is illegal)
//   - state_e          : load/store unit FSM states
package dmem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    FAULT
  } state_e;

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte-lane logic for the load/store unit.
//   word_i     : memory word (load source / read-modify-write base)
//   wdata_i    : right-aligned store data
//   offset_i   : byte offset within the word (addr[1:0])
//   size_i     : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   sign_ext_i : 1 = sign-extend sub-word loads, 0 = zero-extend
//   load_o     : extracted and extended load value
//   merge_o    : word_i with the addressed lane(s) replaced by wdata_i
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lane_data;
  logic [3:0]        lane_en;

  // Little-endian: the addressed lane is brought down to bit 0.
  assign shamt   = {offset_i, 3'b000};
  assign shifted = word_i >> shamt;

  always_comb begin
    load_o = word_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
      default: load_o = word_i;
    endcase
  end

  // Replicating the store data across the word puts the right bytes in
  // every lane; lane_en then picks which lanes actually take them.
  always_comb begin
    lane_en   = 4'b1111;
    lane_data = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        lane_en   = 4'b0001 << offset_i;
        lane_data = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        lane_en   = 4'b0011 << offset_i;
        lane_data = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merge_o[8*gi +: 8] = lane_en[gi] ? lane_data[8*gi +: 8] : word_i[8*gi +: 8];
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the CPU execute stage and a word-only
// data memory. Byte/half/word accesses become word transactions; sub-word
// stores are done as read-modify-write.
//   CPU side   : req, we, size, sign_ext, addr, wdata -> ready, done, err, rdata
//   Memory side: mem_write, mem_addr, mem_wdata -> memory; mem_rdata <- memory
//                (mem_rdata is combinational from mem_addr)
// Optional feature: define DMEM_LSU_BOUNDS_CHECK_EN to fault any access whose
// byte address has bits set above the memory range; otherwise those bits are
// ignored and addresses alias.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              misaligned;
  logic              out_of_range;
  logic              bad_req;
  logic [DATA_W-1:0] lane_load;
  logic [DATA_W-1:0] lane_merge;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

`ifdef DMEM_LSU_BOUNDS_CHECK_EN
  assign out_of_range = |addr[31:ADDR_W+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];
  assign out_of_range   = 1'b0;
`endif

  assign bad_req = misaligned | out_of_range;

  dmem_lane u_lane (
    .word_i     (mem_rdata),
    .wdata_i    (wdata_q),
    .offset_i   (off_q),
    .size_i     (size_q),
    .sign_ext_i (sign_q),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sign_q      <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sign_d      = sign_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d       = we;
          size_d     = size;
          sign_d     = sign_ext;
          off_d      = addr[1:0];
          wdata_d    = wdata;
          mem_addr_d = addr[ADDR_W+1:2];
          if (bad_req) begin
            state_d = FAULT;
          end else if (we && (size == SZ_WORD)) begin
            // Full-word store needs no read; its data goes straight out.
            mem_wdata_d = wdata;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          mem_wdata_d = lane_merge;
          state_d     = WRITE;
        end else begin
          rdata_d = lane_load;
          state_d = DONE;
        end
      end
      WRITE:       state_d = DONE;
      DONE, FAULT: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE) || (state_q == FAULT);
  assign err       = (state_q == FAULT);
  assign mem_write = (state_q == WRITE);
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: bench for dmem_lsu. Holds a word memory as the responder and
// a byte-array reference model; a negedge process compares every cycle.
module tb_dmem_lsu;

  localparam int ADDR_W = 11;
  localparam int NWORDS = 1 << ADDR_W;
  localparam int NBYTES = NWORDS * 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  // Responder memory
  logic [31:0] mem [NWORDS];
  logic        mem_init;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= init_word(i);
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model state
  logic [7:0]        ref_b [NBYTES];
  logic [31:0]       rdata_m;
  logic              exp_ready, exp_done, exp_err, exp_mw;
  logic [ADDR_W-1:0] exp_ma;
  logic [31:0]       exp_mwd;
  logic              chk_en;
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(ready), 32'(exp_ready));
      check("done", 32'(done), 32'(exp_done));
      if (exp_done) check("err", 32'(err), 32'(exp_err));
      check("mem_write", 32'(mem_write), 32'(exp_mw));
      check("rdata", rdata, rdata_m);
      if (exp_mw) begin
        check("mem_addr", 32'(mem_addr), 32'(exp_ma));
        check("mem_wdata", mem_wdata, exp_mwd);
      end
    end
  end

  task automatic set_idle();
    exp_ready = 1'b1;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_mw    = 1'b0;
  endtask

  function automatic logic [31:0] ref_word(input int wi);
    return {ref_b[4*wi+3], ref_b[4*wi+2], ref_b[4*wi+1], ref_b[4*wi]};
  endfunction

  task automatic scramble_inputs(input int busy_mode);
    req      = (busy_mode == 2) ? 1'b1 : (busy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    we       = 1'($urandom_range(0, 1));
    size     = 2'($urandom_range(0, 3));
    sign_ext = 1'($urandom_range(0, 1));
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  // One CPU access. rst_at >= 0 asserts reset during busy cycle rst_at.
  task automatic txn(input logic st, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int rst_at, input int busy_mode);
    logic        fault;
    int          nb, lat, wi, off;
    logic [63:0] v;
    logic [31:0] ld;
    logic [7:0]  nw [4];
    fault = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`ifdef DMEM_LSU_BOUNDS_CHECK_EN
    if (a >= 32'(NBYTES)) fault = 1'b1;
`endif
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    lat = fault ? 1 : (!st || sz == 2'b10) ? 2 : 3;
    wi  = int'(a[ADDR_W+1:2]);
    off = int'(a[1:0]);
    ld  = '0;
    for (int k = 0; k < 4; k++) nw[k] = ref_b[4*wi+k];
    if (!fault) begin
      v = '0;
      for (int k = 0; k < nb; k++) v = v | (64'(ref_b[4*wi+off+k]) << (8*k));
      if (sx && nb < 4 && v[8*nb-1]) v = v | (~64'h0 << (8*nb));
      ld = v[31:0];
      for (int k = 0; k < nb; k++) nw[off+k] = wd[8*k +: 8];
    end
    req = 1'b1; we = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(posedge clk); #1;
    for (int j = 0; j < lat; j++) begin
      scramble_inputs(busy_mode);
      exp_ready = 1'b0;
      exp_done  = (j == lat - 1);
      exp_err   = fault;
      exp_mw    = !fault && st && (j == lat - 2);
      exp_ma    = a[ADDR_W+1:2];
      exp_mwd   = {nw[3], nw[2], nw[1], nw[0]};
      if (!fault && !st && j == lat - 1) rdata_m = ld;
      if (j == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req = 1'b0;
        set_idle();
        rdata_m = '0;
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        return;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    set_idle();
    if (!fault && st) for (int k = 0; k < 4; k++) ref_b[4*wi+k] = nw[k];
    $display("txn we=%0d size=%0d sx=%0d addr=%h wdata=%h fault=%0d rdata=%h",
             st, sz, sx, a, wd, fault, rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      scramble_inputs(0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic        st, sx;
    logic [1:0]  sz;
    logic [31:0] a;
    chk_en = 1'b0;
    rst = 1'b1; mem_init = 1'b1;
    req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < NWORDS; i++) begin
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = init_word(i) >> (8*k);
    end
    rdata_m = '0;
    exp_ma = '0; exp_mwd = '0;
    set_idle();
    @(posedge clk); #1;
    mem_init = 1'b0;
    chk_en = 1'b1;
    check("reset_mem_addr", 32'(mem_addr), 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Word store, then byte loads
    txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, -1, 0);
    check("pin_sw_mem", mem[4], 32'h11223344);
    txn(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, -1, 0);
    check("pin_lbu", rdata, 32'h00000033);
    txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, -1, 0);
    check("pin_lb", rdata, 32'h00000011);

    // Sub-word read-modify-write
    txn(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, -1, 0);
    check("pin_sh_mem", mem[4], 32'hBEEF3344);
    txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, -1, 0);
    check("pin_lh", rdata, 32'hFFFFBEEF);
    txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, -1, 0);
    check("pin_lhu", rdata, 32'h0000BEEF);
    txn(1'b1, 2'b00, 1'b0, 32'h10, 32'h00000080, -1, 0);
    txn(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, -1, 0);
    check("pin_lb_neg", rdata, 32'hFFFFFF80);

    // Faults leave memory and rdata alone
    txn(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, -1, 1);
    txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, -1, 1);
    txn(1'b1, 2'b10, 1'b0, 32'h12, 32'hDEADBEEF, -1, 1);
    check("pin_fault_mem", mem[4], 32'hBEEF3380);
    check("pin_fault_rdata", rdata, 32'hFFFFFF80);

    // Reset during the read phase of a byte store
    txn(1'b1, 2'b00, 1'b0, 32'h20, 32'h000000AA, 0, 0);
    idle(1);
    check("pin_rst_mem", mem[8], init_word(8));

    // Bounds / aliasing
    txn(1'b0, 2'b10, 1'b0, 32'h00002000, 32'h0, -1, 0);
`ifdef DMEM_LSU_BOUNDS_CHECK_EN
    check("pin_bounds", rdata, 32'h00000000);
`else
    check("pin_bounds", rdata, 32'hA5A55A5A);
`endif

    // Back-to-back loads with req held high while busy
    for (int n = 0; n < 10; n++) begin
      if (n % 2 == 0) txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, -1, 2);
      else            txn(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, -1, 2);
    end

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 0) a = a + 32'h1FC0;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a = a & ~32'h1;
        if (sz == 2'b10) a = a & ~32'h3;
      end
      if ($urandom_range(0, 7) == 0) a = a | ($urandom << (ADDR_W + 2));
      txn(st, sz, sx, a, $urandom, -1, 1);
      idle(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
